// File: rtl/stab_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one stab injection port among N flit sources.
// Ownership spans head..tail so packets never interleave; includes stall watchdog and diagnostics.
module stab_inject_arbiter #(
  parameter int N           = 4,
  parameter int DW          = 16,
  parameter int STALL_LIMIT = 10000,
  parameter int CNTW        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] req_data_i,
  input  logic [N-1:0]    req_valid_i,
  output logic [N-1:0]    req_ready_o,
  output logic [DW-1:0]   data_o_stab,
  output logic            valid_o_stab,
  input  logic            ready_i_stab,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic [CNTW-1:0] pkt_cnt_o,
  output logic            proto_err_o
);

  localparam int OW = $clog2(N);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

  state_t          state_r, state_n;
  logic [OW-1:0]   owner_r, owner_n;
  logic [OW-1:0]   rr_r, rr_n;
  logic            first_r, first_n;
  logic [SW-1:0]   stall_cnt_r, stall_cnt_n;
  logic [CNTW-1:0] pkt_cnt_r;
  logic            proto_err_r;

  logic [DW-1:0]   flit_s [N];
  logic [N-1:0]    hd_s;
  logic [DW-1:0]   owner_flit_s;
  logic            active_s;
  logic            hs_s;
  logic            win_found_s;
  logic [OW-1:0]   win_idx_s;
  logic [OW:0]     sum_s;
  logic            idle_err_s;
  logic            err_set_s;
  logic            pkt_inc_s;

  // Type bit DW-2 is set for head (01) and single (11): the flits that may open a packet.
  for (genvar k = 0; k < N; k++) begin : g_src
    assign flit_s[k] = req_data_i[k*DW +: DW];
    assign hd_s[k]   = req_data_i[k*DW + DW - 2];
  end

  assign active_s     = (state_r == ST_ACTIVE);
  assign owner_flit_s = flit_s[owner_r];
  assign hs_s         = valid_o_stab & ready_i_stab;
  assign idle_err_s   = |(req_valid_i & ~hd_s);

  // Round-robin search for the first eligible source at or after the rr pointer.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_s       = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, rr_r} + (OW+1)'(i);
      if (sum_s >= (OW+1)'(N)) begin
        sum_s = sum_s - (OW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      if (!win_found_s && req_valid_i[sum_s[OW-1:0]] && hd_s[sum_s[OW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = sum_s[OW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Combinational pass-through of the owner's flit and handshake while ACTIVE.
  always_comb begin
    req_ready_o  = '0;
    grant_o      = '0;
    data_o_stab  = '0;
    valid_o_stab = 1'b0;
    if (active_s) begin
      req_ready_o[owner_r] = ready_i_stab;
      grant_o[owner_r]     = 1'b1;
      data_o_stab          = owner_flit_s;
      valid_o_stab         = req_valid_i[owner_r];
    end else begin
      valid_o_stab = 1'b0;
    end
  end

  // Next-state logic for ownership, rr pointer and error detection.
  always_comb begin
    state_n   = state_r;
    owner_n   = owner_r;
    rr_n      = rr_r;
    first_n   = first_r;
    err_set_s = 1'b0;
    pkt_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        err_set_s = idle_err_s;
        if (win_found_s) begin
          state_n = ST_ACTIVE;
          owner_n = win_idx_s;
          first_n = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (hs_s) begin
          first_n   = 1'b0;
          err_set_s = (owner_flit_s[DW-1:DW-2] == 2'b01) && !first_r;
          if (owner_flit_s[DW-1]) begin
            state_n   = ST_IDLE;
            rr_n      = (owner_r == OW'(N-1)) ? '0 : owner_r + OW'(1);
            pkt_inc_s = 1'b1;
          end else begin
            state_n = ST_ACTIVE;
          end
        end else begin
          first_n = first_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Watchdog counts back-pressured cycles of the current owner, saturating at the limit.
  always_comb begin
    stall_cnt_n = stall_cnt_r;
    if (!active_s || hs_s) begin
      stall_cnt_n = '0;
    end else if (valid_o_stab && !ready_i_stab && (stall_cnt_r != SW'(STALL_LIMIT))) begin
      stall_cnt_n = stall_cnt_r + SW'(1);
    end else begin
      stall_cnt_n = stall_cnt_r;
    end
  end

  // State and diagnostic registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      rr_r        <= '0;
      first_r     <= 1'b0;
      stall_cnt_r <= '0;
      pkt_cnt_r   <= '0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      owner_r     <= owner_n;
      rr_r        <= rr_n;
      first_r     <= first_n;
      stall_cnt_r <= stall_cnt_n;
      pkt_cnt_r   <= pkt_inc_s ? pkt_cnt_r + CNTW'(1) : pkt_cnt_r;
      proto_err_r <= proto_err_r | err_set_s;
    end
  end

  assign busy_o      = active_s;
  assign stall_o     = (stall_cnt_r == SW'(STALL_LIMIT));
  assign pkt_cnt_o   = pkt_cnt_r;
  assign proto_err_o = proto_err_r;

endmodule

// File: tb/tb_stab_inject_arbiter.sv
// Directed self-checking bench for stab_inject_arbiter (N=4, DW=16, STALL_LIMIT=16).
module tb_stab_inject_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SL = 16;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   data_o_stab;
  logic            valid_o_stab;
  logic            ready_i_stab;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic            stall_o;
  logic [CW-1:0]   pkt_cnt_o;
  logic            proto_err_o;

  int total = 0;
  int bad   = 0;

  // Per-source flit generator state
  int f_a [N];
  int p_a [N];
  int plen_a [N];
  int npk_a [N];
  bit en_a [N];
  bit hs_a [N];

  stab_inject_arbiter #(.N(N), .DW(DW), .STALL_LIMIT(SL), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .data_o_stab(data_o_stab), .valid_o_stab(valid_o_stab), .ready_i_stab(ready_i_stab),
    .grant_o(grant_o), .busy_o(busy_o), .stall_o(stall_o),
    .pkt_cnt_o(pkt_cnt_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fty(input int f, input int plen);
    if (plen == 1) return 2'b11;
    else if (f == 0) return 2'b01;
    else if (f == plen - 1) return 2'b10;
    else return 2'b00;
  endfunction

  function automatic logic [DW-1:0] mk(input int k, input int p, input int f, input int plen);
    return {fty(f, plen), 2'b00, 4'(k), 4'(p), 1'b0, 3'(f)};
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k] = en_a[k];
      req_data_i[k*DW +: DW] = mk(k, p_a[k], f_a[k], plen_a[k]);
    end
  endtask

  task automatic setsrc(input int k, input int plen, input int npk, input int f0);
    en_a[k] = 1'b1; plen_a[k] = plen; npk_a[k] = npk; f_a[k] = f0; p_a[k] = 0;
  endtask

  // Advance one clock: sources move on after an accepted flit; returns at the next negedge.
  task automatic step(input logic rdy);
    for (int k = 0; k < N; k++) hs_a[k] = req_valid_i[k] & req_ready_o[k];
    @(posedge clk); #1;
    ready_i_stab = rdy;
    for (int k = 0; k < N; k++) begin
      if (hs_a[k]) begin
        f_a[k]++;
        if (f_a[k] == plen_a[k]) begin
          f_a[k] = 0; p_a[k]++;
          if (p_a[k] == npk_a[k]) en_a[k] = 1'b0;
        end
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; ready_i_stab = 1'b0;
    for (int k = 0; k < N; k++) begin
      en_a[k] = 1'b0; f_a[k] = 0; p_a[k] = 0; plen_a[k] = 1; npk_a[k] = 1;
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_i_stab = 1'b1;
    for (int k = 0; k < N; k++) begin
      en_a[k] = 1'b1; f_a[k] = 0; p_a[k] = 0; plen_a[k] = 2; npk_a[k] = 1;
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL reset_grant got %b want 0000", grant_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    total++; if (valid_o_stab !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_o_stab); end
    total++; if (req_ready_o !== 4'b0000) begin bad++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall_o); end
    total++; if (pkt_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_pkt got %0d want 0", pkt_cnt_o); end
    total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", proto_err_o); end
  endtask

  task automatic test_single();
    apply_reset();
    setsrc(2, 4, 1, 0); ready_i_stab = 1'b1; drive(); #1;
    total++; if (grant_o !== 4'b0000 || valid_o_stab !== 1'b0) begin bad++; $display("FAIL single_bubble got grant=%b valid=%b want 0000/0", grant_o, valid_o_stab); end
    for (int j = 0; j < 4; j++) begin
      step(1'b1);
      total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL single_grant flit %0d got %b want 0100", j, grant_o); end
      total++; if (data_o_stab !== mk(2, 0, j, 4) || valid_o_stab !== 1'b1) begin bad++; $display("FAIL single_data flit %0d got %h/%b want %h/1", j, data_o_stab, valid_o_stab, mk(2, 0, j, 4)); end
      total++; if (req_ready_o !== 4'b0100) begin bad++; $display("FAIL single_ready flit %0d got %b want 0100", j, req_ready_o); end
    end
    step(1'b1);
    total++; if (pkt_cnt_o !== 32'd1) begin bad++; $display("FAIL single_pkt got %0d want 1", pkt_cnt_o); end
    total++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin bad++; $display("FAIL single_idle got busy=%b grant=%b want 0/0000", busy_o, grant_o); end
    total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL single_err got %b want 0", proto_err_o); end
  endtask

  task automatic test_round_robin();
    int ph, pk, own;
    apply_reset();
    for (int k = 0; k < N; k++) setsrc(k, 3, 4, 0);
    ready_i_stab = 1'b1; drive(); #1;
    for (int c = 0; c < 32; c++) begin
      ph = c % 4; pk = c / 4; own = pk % 4;
      if (ph == 0) begin
        total++; if (busy_o !== 1'b0 || valid_o_stab !== 1'b0) begin bad++; $display("FAIL rr_bubble cyc %0d got busy=%b valid=%b want 0/0", c, busy_o, valid_o_stab); end
      end else begin
        total++; if (grant_o !== 4'(1 << own)) begin bad++; $display("FAIL rr_grant cyc %0d got %b want %b", c, grant_o, 4'(1 << own)); end
        total++; if (data_o_stab !== mk(own, pk / 4, ph - 1, 3)) begin bad++; $display("FAIL rr_data cyc %0d got %h want %h", c, data_o_stab, mk(own, pk / 4, ph - 1, 3)); end
      end
      total++; if (pkt_cnt_o !== 32'(c / 4)) begin bad++; $display("FAIL rr_pkt cyc %0d got %0d want %0d", c, pkt_cnt_o, c / 4); end
      step(1'b1);
    end
    total++; if (pkt_cnt_o !== 32'd8 || busy_o !== 1'b0) begin bad++; $display("FAIL rr_end got pkt=%0d busy=%b want 8/0", pkt_cnt_o, busy_o); end
  endtask

  task automatic test_back_pressure();
    logic rs [7];
    int idx;
    rs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    idx = 0;
    apply_reset();
    setsrc(0, 5, 1, 0); setsrc(1, 2, 1, 0);
    ready_i_stab = 1'b1; drive(); #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL bp_bubble got %b want 0", busy_o); end
    for (int j = 0; j < 7; j++) begin
      step(rs[j]);
      total++; if (data_o_stab !== mk(0, 0, idx, 5) || valid_o_stab !== 1'b1) begin bad++; $display("FAIL bp_data cyc %0d got %h/%b want %h/1", j, data_o_stab, valid_o_stab, mk(0, 0, idx, 5)); end
      total++; if (req_ready_o !== {3'b000, rs[j]}) begin bad++; $display("FAIL bp_ready cyc %0d got %b want %b", j, req_ready_o, {3'b000, rs[j]}); end
      if (rs[j]) idx++;
    end
    step(1'b1);
    total++; if (busy_o !== 1'b0 || pkt_cnt_o !== 32'd1) begin bad++; $display("FAIL bp_end got busy=%b pkt=%0d want 0/1", busy_o, pkt_cnt_o); end
    step(1'b1);
    total++; if (grant_o !== 4'b0010 || data_o_stab !== mk(1, 0, 0, 2)) begin bad++; $display("FAIL bp_next got %b/%h want 0010/%h", grant_o, data_o_stab, mk(1, 0, 0, 2)); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    setsrc(0, 2, 1, 0); ready_i_stab = 1'b0; drive(); #1;
    for (int j = 0; j < 20; j++) begin
      step(1'b0);
      if (j == 15) begin
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL wd_early cyc %0d got %b want 0", j, stall_o); end
      end else if (j >= 16) begin
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL wd_trip cyc %0d got %b want 1", j, stall_o); end
      end
    end
    total++; if (data_o_stab !== mk(0, 0, 0, 2)) begin bad++; $display("FAIL wd_hold got %h want %h", data_o_stab, mk(0, 0, 0, 2)); end
    step(1'b1);
    total++; if (stall_o !== 1'b1 || req_ready_o !== 4'b0001) begin bad++; $display("FAIL wd_pulse got stall=%b ready=%b want 1/0001", stall_o, req_ready_o); end
    step(1'b0);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL wd_clear got %b want 0", stall_o); end
    total++; if (data_o_stab !== mk(0, 0, 1, 2)) begin bad++; $display("FAIL wd_tail got %h want %h", data_o_stab, mk(0, 0, 1, 2)); end
    step(1'b1);
    step(1'b0);
    total++; if (pkt_cnt_o !== 32'd1 || busy_o !== 1'b0) begin bad++; $display("FAIL wd_end got pkt=%0d busy=%b want 1/0", pkt_cnt_o, busy_o); end
  endtask

  task automatic test_proto_single();
    apply_reset();
    setsrc(1, 4, 1, 1); ready_i_stab = 1'b1; drive(); #1;
    total++; if (proto_err_o !== 1'b0 || grant_o !== 4'b0000) begin bad++; $display("FAIL pe_pre got err=%b grant=%b want 0/0000", proto_err_o, grant_o); end
    step(1'b1);
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL pe_set got %b want 1", proto_err_o); end
    total++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin bad++; $display("FAIL pe_nogrant got busy=%b grant=%b want 0/0000", busy_o, grant_o); end
    en_a[1] = 1'b0; setsrc(3, 1, 3, 0); drive(); #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      total++; if (grant_o !== 4'b1000 || data_o_stab !== mk(3, i, 0, 1)) begin bad++; $display("FAIL sg_flit %0d got %b/%h want 1000/%h", i, grant_o, data_o_stab, mk(3, i, 0, 1)); end
      total++; if (pkt_cnt_o !== 32'(i)) begin bad++; $display("FAIL sg_cnt_pre %0d got %0d want %0d", i, pkt_cnt_o, i); end
      step(1'b1);
      total++; if (busy_o !== 1'b0 || pkt_cnt_o !== 32'(i + 1)) begin bad++; $display("FAIL sg_cnt %0d got busy=%b pkt=%0d want 0/%0d", i, busy_o, pkt_cnt_o, i + 1); end
    end
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL pe_sticky got %b want 1", proto_err_o); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    setsrc(0, 4, 1, 0); ready_i_stab = 1'b1; drive(); #1;
    repeat (3) step(1'b1);
    total++; if (busy_o !== 1'b1 || data_o_stab !== mk(0, 0, 2, 4)) begin bad++; $display("FAIL rm_pre got busy=%b data=%h want 1/%h", busy_o, data_o_stab, mk(0, 0, 2, 4)); end
    rst = 1'b1; #1;
    total++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin bad++; $display("FAIL rm_grant got grant=%b busy=%b want 0000/0", grant_o, busy_o); end
    total++; if (valid_o_stab !== 1'b0 || req_ready_o !== 4'b0000) begin bad++; $display("FAIL rm_valid got valid=%b ready=%b want 0/0000", valid_o_stab, req_ready_o); end
    total++; if (stall_o !== 1'b0 || proto_err_o !== 1'b0 || pkt_cnt_o !== 32'd0) begin bad++; $display("FAIL rm_diag got stall=%b err=%b pkt=%0d want 0/0/0", stall_o, proto_err_o, pkt_cnt_o); end
    #1; rst = 1'b0;
    step(1'b1);
    total++; if (proto_err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL rm_body got err=%b busy=%b want 1/0", proto_err_o, busy_o); end
    en_a[0] = 1'b0; setsrc(2, 2, 1, 0); drive(); #1;
    step(1'b1);
    total++; if (grant_o !== 4'b0100 || data_o_stab !== mk(2, 0, 0, 2)) begin bad++; $display("FAIL rm_regrant got %b/%h want 0100/%h", grant_o, data_o_stab, mk(2, 0, 0, 2)); end
  endtask

  initial begin
    rst = 1'b1; ready_i_stab = 1'b0; req_valid_i = '0; req_data_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_watchdog();
    test_proto_single();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stab_inject_arbiter.md
Name: stab_inject_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single network injection port (stab: data/valid/ready) among N local flit sources.
- Sits between the injecting sources and the network `system` top.
- Grants one source at a time and holds the grant from the head flit through the tail flit, so packets are never interleaved.
- Provides stall watchdog, packet counter and protocol-error flag for deadlock diagnosis.

Parameters:
- N, 4: number of requesting sources (2..16).
- DW, `DW (params.svh): flit width. Flit type is in bits [DW-1:DW-2]: 00 body, 01 head, 10 tail, 11 single.
- STALL_LIMIT, 10000: consecutive back-pressured cycles before stall_o asserts.
- CNTW, 32: width of the packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_data_i  in  N*DW  source flits; source k occupies [k*DW +: DW].
- req_valid_i  in  N  per-source flit valid.
- req_ready_o  out  N  per-source ready; only the owner's bit can be 1.
- data_o_stab  out  DW  flit to network injection port.
- valid_o_stab  out  1  flit valid to network.
- ready_i_stab  in  1  network ready.
- grant_o  out  N  one-hot current owner; all zero when not ACTIVE.
- busy_o  out  1  1 while in ACTIVE.
- stall_o  out  1  back-pressure watchdog tripped.
- pkt_cnt_o  out  CNTW  packets (tail or single accepted) forwarded since reset; wraps.
- proto_err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=1, async): state IDLE, owner 0, rr pointer 0, stall counter 0, pkt_cnt_o 0, proto_err_o 0. Outputs: grant_o 0, busy_o 0, valid_o_stab 0, req_ready_o 0, stall_o 0.
- Reset mid-packet drops ownership without completing the packet. After reset release, the next grant again requires a head or single flit.
- States: IDLE, ACTIVE.
- IDLE:
  - Eligible source = req_valid_i[k]=1 and flit type head or single.
  - Winner = first eligible index at or after the rr pointer, searching upward modulo N.
  - If a winner exists: register owner=winner and move to ACTIVE next cycle.
  - IDLE drives valid_o_stab=0 and req_ready_o=0. This gives a fixed 1-cycle arbitration bubble per packet.
  - A valid source presenting body or tail in IDLE is not eligible and sets proto_err_o.
- ACTIVE:
  - data_o_stab = owner's flit. valid_o_stab = req_valid_i[owner]. req_ready_o[owner] = ready_i_stab; all other bits 0. Pure combinational pass-through, zero added latency.
  - A handshake occurs when valid_o_stab & ready_i_stab.
  - Handshake on a tail or single flit: return to IDLE, rr pointer = (owner+1) mod N, pkt_cnt_o += 1.
  - Handshake on a head or body flit: stay ACTIVE.
  - A handshake on a head flit other than the packet's first flit sets proto_err_o; the flit is still forwarded.
- Input validity: the arbiter does not filter flits; sources must hold data stable while valid and not ready.
- Watchdog:
  - Counter increments each cycle valid_o_stab & ~ready_i_stab, saturating at STALL_LIMIT.
  - Counter clears on any handshake and in IDLE.
  - stall_o = (counter == STALL_LIMIT); it holds until the counter clears.
- proto_err_o clears only on reset.
- Simultaneous events: a tail handshake and new requests in the same cycle give IDLE next cycle, then the new grant the cycle after. The owner cannot be re-granted back-to-back while another eligible source is waiting.

Test Plan:
- Single source: N=4, source 2 sends head, body, body, tail with ready_i_stab=1.
  - grant_o=0100 in the cycle after the head first appears.
  - 4 flits appear on data_o_stab in consecutive cycles, in order.
  - pkt_cnt_o=1, then IDLE.
- Round-robin fairness: all 4 sources continuously offer 3-flit packets.
  - Grant order is 0,1,2,3,0,…, with no flit interleaving.
  - After 8 packets, pkt_cnt_o=8.
  - Exactly 1 idle cycle between packets.
- Back-pressure: ready_i_stab toggles 1,0,0,1 during a 5-flit packet.
  - data_o_stab holds stable while stalled.
  - The owner's req_ready_o mirrors ready_i_stab; other sources' ready stays 0.
  - No flit is lost or duplicated.
- Watchdog: STALL_LIMIT=16, ready_i_stab held 0 with valid_o_stab=1.
  - stall_o rises on the 16th stalled cycle and holds.
  - A single ready pulse clears it the next cycle.
- Protocol error and single flits:
  - Source 1 presents a body flit in IDLE: it is not granted and proto_err_o=1 (sticky).
  - Source 3 single flits are accepted in one flit each, and pkt_cnt_o increments per flit.
- Reset mid-packet: assert rst after 2 of 4 flits.
  - All outputs return to reset values immediately.
  - After release, the source's pending body flit is ignored and sets proto_err_o.
  - The next head from any source is granted normally.
